// File: rtl/uart_tx_line_buffer_pkg.sv
// uart_tx_pkg: shared character type, control-char constants and flush FSM states
package uart_tx_pkg;
  typedef logic [7:0] uart_char_t;
  localparam uart_char_t UART_CH_LF = 8'h0A;
  localparam uart_char_t UART_CH_CR = 8'h0D;
  typedef enum logic {IDLE, DRAIN} linebuf_state_e;
endpackage

// File: rtl/uart_tx_line_buffer_if.sv
// uart_tx_line_buffer_if: UART char strobe in, valid/ready console stream out
interface uart_tx_line_buffer_if;
  import uart_tx_pkg::*;
  logic       in_valid;
  uart_char_t in_ch;
  logic       out_valid;
  uart_char_t out_ch;
  logic       out_last;
  logic       out_ready;
  modport master (output in_valid, in_ch, out_ready, input out_valid, out_ch, out_last);
  modport slave (input in_valid, in_ch, out_ready, output out_valid, out_ch, out_last);
endinterface

// File: rtl/uart_tx_line_buffer_fifo.sv
// uart_tx_fifo: first-word fall-through FIFO with occupancy count; caller never overflows or underflows it
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  uart_char_t    din_i,
  input  logic          pop_i,
  output uart_char_t    dout_o,
  output logic [AW:0]   count_o
);
  uart_char_t      mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     cnt_q;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push_i);
      rd_q  <= rd_q + AW'(pop_i);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  // storage needs no reset; contents are only observed when count is non-zero
  always_ff @(posedge clock)
    if (push_i) mem_q[wr_q] <= din_i;
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/uart_tx_line_buffer.sv
// uart_tx_line_buffer: buffers UART chars and releases them in line bursts; define UART_TX_LINEBUF_STRIP_CR_EN to discard CR at the input
module uart_tx_line_buffer
  import uart_tx_pkg::*;
#(
  parameter int DEPTH          = 64,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int CNT_W          = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                clock,
  input  logic                reset,
  uart_tx_line_buffer_if.slave bus,
  output logic                busy,
  output logic [CNT_W-1:0]    overflow_cnt
);
  linebuf_state_e state_q, state_d;
  logic [AW:0]    count, nl_cnt_q, nl_cnt_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;
  logic           take, full, push, pop, drop;
  uart_char_t     head;

`ifdef UART_TX_LINEBUF_STRIP_CR_EN
  assign take = bus.in_valid & (bus.in_ch != UART_CH_CR);
`else
  assign take = bus.in_valid;
`endif

  assign full          = count == (AW+1)'(DEPTH);
  assign bus.out_valid = (state_q == DRAIN) & (count != '0);
  assign bus.out_ch    = head;
  assign bus.out_last  = bus.out_valid & ((head == UART_CH_LF) | (count == (AW+1)'(1)));
  assign pop           = bus.out_valid & bus.out_ready;
  assign push          = take & (!full | pop);
  assign drop          = take & full & !pop;
  assign busy          = state_q == DRAIN;
  assign overflow_cnt  = ovf_q;

  uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .din_i   (bus.in_ch),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (count)
  );

  // newline tally, idle timer and saturating drop counter
  always_comb begin
    nl_cnt_d = nl_cnt_q + (AW+1)'(push & (bus.in_ch == UART_CH_LF)) - (AW+1)'(pop & (head == UART_CH_LF));
    timer_d  = (push | (count == '0)) ? '0 :
               ((state_q == IDLE) & (timer_q != TW'(TIMEOUT_CYCLES))) ? timer_q + 1'b1 : timer_q;
    ovf_d    = (drop & ~&ovf_q) ? ovf_q + 1'b1 : ovf_q;
  end

  // flush trigger from registered state; a burst ends on the handshake of its last char
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE)
      state_d = ((nl_cnt_q != '0) | full | ((timer_q == TW'(TIMEOUT_CYCLES)) & (count != '0))) ? DRAIN : IDLE;
    else
      state_d = ((pop & bus.out_last) | (count == '0)) ? IDLE : DRAIN;
  end

  // control state registers
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q  <= IDLE;
      nl_cnt_q <= '0;
      timer_q  <= '0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      nl_cnt_q <= nl_cnt_d;
      timer_q  <= timer_d;
      ovf_q    <= ovf_d;
    end
endmodule

// File: tb/tb_uart_tx_line_buffer.sv
// tb_uart_tx_line_buffer: directed and random stimulus against a queue model of the line buffer
module tb_uart_tx_line_buffer;
  localparam int DEPTH = 4;
  localparam int TO    = 16;
  localparam int CW    = 4;
  localparam int OVF_MAX = (1 << CW) - 1;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;
`ifdef UART_TX_LINEBUF_STRIP_CR_EN
  localparam bit STRIP = 1'b1;
`else
  localparam bit STRIP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic busy;
  logic [CW-1:0] overflow_cnt;
  uart_tx_line_buffer_if bus();

  uart_tx_line_buffer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .busy         (busy),
    .overflow_cnt (overflow_cnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;
  logic [7:0] q[$];
  int drops = 0;
  int n_out = 0;
  int mdl_n;
  bit mdl_pop;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    checks++;
    if (act === ex) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, ex, $time);
  endtask

  // reference model: FIFO contents as a queue, flush/last rules taken from the behaviour description
  always @(negedge clock) begin
    if (!reset) begin
      q.delete();
      drops = 0;
    end else begin
      mdl_n   = q.size();
      mdl_pop = bus.out_valid & bus.out_ready;
      if (mdl_n == 0) chk("valid_when_empty", 32'(bus.out_valid), 0);
      if (mdl_pop && mdl_n > 0) begin
        chk("out_ch", 32'(bus.out_ch), 32'(q[0]));
        chk("out_last", 32'(bus.out_last), 32'((q[0] == LF) || (mdl_n == 1)));
        void'(q.pop_front());
        n_out++;
      end
      if (bus.in_valid && !(STRIP && bus.in_ch == CR)) begin
        if (mdl_n < DEPTH || mdl_pop) q.push_back(bus.in_ch);
        else if (drops < OVF_MAX) drops++;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      bus.in_valid = 1'b1;
      bus.in_ch    = s[i];
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while ((busy || q.size() > 0) && k < limit) begin
      step();
      k++;
    end
    chk("drain_within_bound", 32'(k < limit), 1);
  endtask

  logic b[14];
  int f_idx, r_idx, rises, n0;
  bit seen;
  logic [7:0] ch0;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_ch     = 8'h00;
    bus.out_ready = 1'b0;
    step();
    step();
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_out_last", 32'(bus.out_last), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_overflow", 32'(overflow_cnt), 0);
    reset = 1'b1;
    step();

    // "hi\n": first char valid two edges after the newline push
    bus.out_ready = 1'b1;
    send("hi\n");
    chk("hi_not_yet_valid", 32'(bus.out_valid), 0);
    step();
    chk("hi_valid_latency", 32'(bus.out_valid), 1);
    chk("hi_busy", 32'(busy), 1);
    step();
    step();
    chk("hi_busy_mid", 32'(busy), 1);
    step();
    chk("hi_busy_fall", 32'(busy), 0);
    wait_idle(20);

    // "abc" with no newline waits out the idle timeout
    send("abc");
    seen = 1'b0;
    for (int i = 0; i < TO; i++) begin
      step();
      if (bus.out_valid) seen = 1'b1;
    end
    chk("timeout_no_early_output", 32'(seen), 0);
    step();
    chk("timeout_flush", 32'(bus.out_valid), 1);
    wait_idle(20);

    // six chars into a four-deep FIFO with the sink stalled
    bus.out_ready = 1'b0;
    send("abcdef");
    chk("full_busy", 32'(busy), 1);
    chk("full_overflow_model", 32'(overflow_cnt), 32'(drops));
    chk("full_overflow_two", 32'(overflow_cnt), 2);
    bus.out_ready = 1'b1;
    n0 = n_out;
    wait_idle(20);
    chk("full_four_out", 32'(n_out - n0), 4);

    // two lines back to back: two bursts with a single idle cycle between them
    for (int i = 0; i < 14; i++) begin
      if (i < 4) begin
        bus.in_valid = 1'b1;
        bus.in_ch    = (i == 0) ? "x" : (i == 2) ? "y" : LF;
      end else bus.in_valid = 1'b0;
      step();
      b[i] = busy;
    end
    bus.in_valid = 1'b0;
    f_idx = -1;
    r_idx = -1;
    rises = 0;
    for (int i = 1; i < 14; i++) begin
      if (!b[i-1] && b[i]) begin
        rises++;
        if (f_idx >= 0 && r_idx < 0) r_idx = i;
      end
      if (b[i-1] && !b[i] && f_idx < 0) f_idx = i;
    end
    chk("two_bursts", 32'(rises), 2);
    chk("burst_gap", 32'(r_idx - f_idx), 1);
    chk("nl_cnt_zero", 32'(dut.nl_cnt_q), 0);

    // sink stalls mid-burst while 'z' keeps arriving
    send("ab\n");
    step();
    step();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_ch     = "z";
    ch0 = bus.out_ch;
    chk("stall_head_b", 32'(ch0), 32'("b"));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", 32'(bus.out_valid), 1);
      chk("stall_ch", 32'(bus.out_ch), 32'(ch0));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n0 = n_out;
    wait_idle(100);
    chk("stall_out_count", 32'(n_out - n0), 4);

    // reset during a burst clears everything at once
    bus.out_ready = 1'b0;
    send("ab\n");
    step();
    step();
    chk("rst_pre_busy", 32'(busy), 1);
    #1 reset = 1'b0;
    #1;
    chk("rst_async_valid", 32'(bus.out_valid), 0);
    chk("rst_async_busy", 32'(busy), 0);
    chk("rst_async_ovf", 32'(overflow_cnt), 0);
    step();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < TO + 8; i++) begin
      step();
      if (bus.out_valid) seen = 1'b1;
    end
    chk("rst_no_stale", 32'(seen), 0);

    // carriage return handling
    n0 = n_out;
    send("a\r\n");
    wait_idle(40);
    chk("cr_out_count", 32'(n_out - n0), STRIP ? 2 : 3);

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 9);
      bus.in_valid  = $urandom_range(0, 1);
      bus.in_ch     = (r == 0) ? LF : (r == 1) ? CR : 8'(8'h61 + $urandom_range(0, 25));
      bus.out_ready = $urandom_range(0, 9) < 7;
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle(200);
    chk("rand_overflow", 32'(overflow_cnt), 32'(drops));
    chk("rand_empty", 32'(q.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
